// File: rtl/pipeline_branch_predictor.sv
// Fetch-stage next-PC predictor: direct-mapped BTB with saturating direction
// counters, a non-speculative return address stack and a mispredict counter.
// Lookup is purely combinational; training happens on the clock edge from
// execute-stage resolution, with no bypass from update to lookup.
module pipeline_branch_predictor #(
    parameter int INDEX_BITS   = 6,
    parameter int TAG_BITS     = 8,
    parameter int COUNTER_BITS = 2,
    parameter int RAS_DEPTH    = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_pc,
    output logic        predict_hit,
    output logic        predict_taken,
    output logic [31:0] predict_target,
    input  logic        update_valid,
    input  logic [31:0] update_pc,
    input  logic [1:0]  update_kind,
    input  logic        update_is_call,
    input  logic        update_taken,
    input  logic [31:0] update_target,
    input  logic        update_mispredict,
    output logic [31:0] mispredict_count
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int PW      = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW      = $clog2(RAS_DEPTH + 1);
    localparam int TAG_LO  = INDEX_BITS + 2;
    localparam int TAG_HI  = INDEX_BITS + TAG_BITS + 1;

    localparam logic [COUNTER_BITS-1:0] CTR_MAX  = '1;
    localparam logic [COUNTER_BITS-1:0] CTR_INIT = COUNTER_BITS'(1) << (COUNTER_BITS - 1);

    localparam logic [1:0] K_COND = 2'd0;
    localparam logic [1:0] K_JUMP = 2'd1;
    localparam logic [1:0] K_RET  = 2'd2;
    localparam logic [1:0] K_RSVD = 2'd3;

    // BTB storage
    logic                    r_valid  [ENTRIES];
    logic [TAG_BITS-1:0]     r_tag    [ENTRIES];
    logic [31:0]             r_target [ENTRIES];
    logic [1:0]              r_kind   [ENTRIES];
    logic [COUNTER_BITS-1:0] r_ctr    [ENTRIES];

    // Return stack: r_ras_ptr is the next push slot, top sits one below it.
    logic [31:0]   r_ras [RAS_DEPTH];
    logic [PW-1:0] r_ras_ptr;
    logic [CW-1:0] r_ras_cnt;

    logic [31:0]   r_mis_cnt;

    logic [INDEX_BITS-1:0]   w_f_idx;
    logic [TAG_BITS-1:0]     w_f_tag;
    logic                    w_f_hit;
    logic                    w_dir;
    logic [INDEX_BITS-1:0]   w_u_idx;
    logic [TAG_BITS-1:0]     w_u_tag;
    logic                    w_u_hit;
    logic                    w_u_en;
    logic                    w_push;
    logic                    w_pop;
    logic [31:0]             w_ret_addr;
    logic [PW-1:0]           w_ras_top;
    logic [PW-1:0]           w_ras_inc;
    logic                    w_ras_empty;
    logic [COUNTER_BITS-1:0] w_ctr_cur;
    logic [COUNTER_BITS-1:0] w_ctr_nxt;
    logic                    w_unused;

    // Address fields outside index/tag do not take part in the lookup.
    assign w_unused = ^{fetch_pc[1:0], fetch_pc[31:TAG_HI+1]};

    assign w_f_idx = fetch_pc[INDEX_BITS+1:2];
    assign w_f_tag = fetch_pc[TAG_HI:TAG_LO];
    assign w_f_hit = fetch_valid & r_valid[w_f_idx] & (r_tag[w_f_idx] == w_f_tag);

    assign w_ras_empty = (r_ras_cnt == '0);
    assign w_ras_top   = (r_ras_ptr == '0) ? PW'(RAS_DEPTH - 1) : r_ras_ptr - PW'(1);
    assign w_ras_inc   = (r_ras_ptr == PW'(RAS_DEPTH - 1)) ? '0 : r_ras_ptr + PW'(1);

    // Direction from the stored kind: counter MSB, always, or non-empty RAS.
    always_comb begin
        w_dir = 1'b0;
        case (r_kind[w_f_idx])
            K_COND:  w_dir = r_ctr[w_f_idx][COUNTER_BITS-1];
            K_JUMP:  w_dir = 1'b1;
            K_RET:   w_dir = ~w_ras_empty;
            default: w_dir = 1'b0;
        endcase
    end

    assign predict_hit    = w_f_hit;
    assign predict_taken  = w_f_hit & w_dir;
    assign predict_target = !predict_taken               ? 32'd0 :
                            (r_kind[w_f_idx] == K_RET)   ? r_ras[w_ras_top] :
                                                           r_target[w_f_idx];

    assign w_u_idx    = update_pc[INDEX_BITS+1:2];
    assign w_u_tag    = update_pc[TAG_HI:TAG_LO];
    assign w_u_hit    = r_valid[w_u_idx] & (r_tag[w_u_idx] == w_u_tag);
    assign w_u_en     = update_valid & (update_kind != K_RSVD);
    assign w_push     = w_u_en & update_is_call & update_taken;
    assign w_pop      = w_u_en & (update_kind == K_RET) & update_taken;
    assign w_ret_addr = update_pc + 32'd4;

    // Saturating counter step for the entry being trained.
    always_comb begin
        w_ctr_cur = r_ctr[w_u_idx];
        w_ctr_nxt = w_ctr_cur;
        if (update_taken) begin
            if (w_ctr_cur != CTR_MAX) w_ctr_nxt = w_ctr_cur + COUNTER_BITS'(1);
        end else begin
            if (w_ctr_cur != '0) w_ctr_nxt = w_ctr_cur - COUNTER_BITS'(1);
        end
    end

    // BTB training: refresh on hit, allocate only on a taken miss.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_kind[i]   <= '0;
                r_ctr[i]    <= '0;
            end
        end else if (w_u_en) begin
            if (w_u_hit) begin
                r_target[w_u_idx] <= update_target;
                r_kind[w_u_idx]   <= update_kind;
                if (update_kind == K_COND) r_ctr[w_u_idx] <= w_ctr_nxt;
            end else if (update_taken) begin
                r_valid[w_u_idx]  <= 1'b1;
                r_tag[w_u_idx]    <= w_u_tag;
                r_target[w_u_idx] <= update_target;
                r_kind[w_u_idx]   <= update_kind;
                r_ctr[w_u_idx]    <= CTR_INIT;
            end
        end
    end

    // Return stack: circular push overwrites the oldest, pop on empty is a no-op.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RAS_DEPTH; i++) r_ras[i] <= '0;
            r_ras_ptr <= '0;
            r_ras_cnt <= '0;
        end else if (w_push && w_pop) begin
            r_ras[w_ras_top] <= w_ret_addr;
        end else if (w_push) begin
            r_ras[r_ras_ptr] <= w_ret_addr;
            r_ras_ptr        <= w_ras_inc;
            if (r_ras_cnt != CW'(RAS_DEPTH)) r_ras_cnt <= r_ras_cnt + CW'(1);
        end else if (w_pop && !w_ras_empty) begin
            r_ras_ptr <= w_ras_top;
            r_ras_cnt <= r_ras_cnt - CW'(1);
        end
    end

    // Free-running mispredict counter, wraps naturally.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_mis_cnt <= '0;
        else if (update_valid && update_mispredict) r_mis_cnt <= r_mis_cnt + 32'd1;
    end

    assign mispredict_count = r_mis_cnt;

endmodule
